instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the simple processor. It drives the processor's 9-bit `din` input.
- It holds a small program memory and a program counter, and tracks the processor's one-hot tick to present the right word at the right time: the instruction word on tick 1, and the immediate word on tick 2 for ADDI/MOVI.
- It provides start, halt and program-load control so a program can be loaded and executed without toggling switches per word.

Parameters:
- DIN_WIDTH, 9, instruction/immediate word width.
- ADDR_W, 6, program-memory address width.
- DEPTH, 64, number of program words (must be ≤ 2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  4  processor tick, one-hot: 0001/0010/0100/1000.
- start  input  1  single-cycle pulse that begins execution from address 0.
- prog_we  input  1  program-memory write enable.
- prog_addr  input  ADDR_W  program-memory write address.
- prog_data  input  DIN_WIDTH  program-memory write data.
- din  output  DIN_WIDTH  word presented to the processor (combinational).
- pc  output  ADDR_W  current program counter.
- running  output  1  high in ARMED or RUN.
- halted  output  1  high in HALT.
- instr_count  output  16  count of instructions issued since the last start.

Behaviour:
- Reset (synchronous, active-high):
  - state=LOAD, pc=0, instr_count=0, cur_imm=0, din=0, running=0, halted=0.
  - Memory contents are NOT reset.
- Opcodes: 000=HALT, 001=ADD, 010=ADDI, 011=SUB, 111=MOVI. Any other opcode is a one-word instruction.
- Immediate-type opcodes: ADDI (010) and MOVI (111). They occupy two consecutive words: the instruction, then the immediate.
- Memory: read is asynchronous (`mem[pc]`); write is synchronous.
  - prog_we is honoured only in LOAD or HALT; it is ignored in ARMED and RUN.
- "Fetch slot": (state==RUN, or state==ARMED) and tick==0001.
- din:
  - Equals mem[pc] during a fetch slot.
  - Equals mem[pc] in RUN with tick==0010 and cur_imm=1.
  - Equals 0 otherwise. A zero word is a NOP to the processor.
- States:
  - LOAD: din=0.
    - start → ARMED, pc<=0, instr_count<=0.
  - ARMED: waits for a tick boundary.
    - On the first cycle with tick==0001, act as a fetch slot and move to RUN.
  - RUN:
    - Fetch slot, instruction word opcode==000: → HALT. pc unchanged. Count not incremented. din is still the HALT word (a processor NOP).
    - Fetch slot, any other opcode: instr_count<=instr_count+1 (wraps at 16 bits); cur_imm<=(opcode∈{010,111}); pc<=pc+1.
    - tick==0010 and cur_imm=1: pc<=pc+1; cur_imm<=0.
    - Other ticks: no change.
  - HALT: din=0, halted=1.
    - start → ARMED, pc<=0, instr_count<=0.
- End of memory:
  - Any pc increment from DEPTH-1 → state<=HALT, pc stays DEPTH-1. There is no wrap-around.
  - If the instruction at DEPTH-1 is immediate-type, its immediate slot sees din=0 (HALT state).
- Simultaneous events:
  - rst dominates everything.
  - start in ARMED or RUN is ignored.
  - start in the same cycle as prog_we in LOAD: the write completes and the state moves to ARMED.
- Reset mid-instruction: the block returns to LOAD with din=0. The processor is reset by the same rst.
- Latency: din is combinational from pc/state/tick, so the word is valid in the same cycle the processor latches it on the clk edge.

Decomposition:
- Shared package holds the constants:
  - opcode values (HALT, ADD, ADDI, SUB, MOVI);
  - one-hot tick constants (T1..T4);
  - state encodings (LOAD, ARMED, RUN, HALT);
  - DIN_WIDTH.
- One natural sub-module, `prog_mem`: a DEPTH×DIN_WIDTH array with synchronous write port and asynchronous read port.
- The FSM, pc, and counter live in `instr_fetch`.

Test Plan:
1. Load mem[0]=9'b111000000 (MOVI R0), mem[1]=9'd5, mem[2]=9'b001000000 (ADD R0,R0), mem[3]=0, then start; cycle tick 0001→1000.
   - Required: din=0x1C0 at first T1; din=5 at T2; din=0x040 at next T1.
   - HALT at pc=3; instr_count=2.
   - Processor R0 ends at 10.
2. Start asserted while tick==0100.
   - Required: din stays 0 until tick==0001.
   - First fetch is mem[0]; running=1 from the cycle after start.
3. Fill all 64 words with 9'b001000000 and start.
   - Required: pc reaches 63, then HALT with pc=63.
   - instr_count=64; no wrap to 0.
4. mem[63]=9'b010001000 (ADDI) executed last.
   - Required: din=0 on the following T2; halted=1.
5. prog_we pulses during RUN to addr 0 with data 0x1FF.
   - Required: memory is unchanged; mem[0] reads back the old value after HALT.
6. rst asserted in RUN during tick==0010 of a MOVI.
   - Required: next cycle state=LOAD, pc=0, din=0, instr_count=0.
   - Memory retained; a subsequent start re-executes the program identically.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: opcodes, one-hot tick values,
// FSM state encoding and the default word width.
package instr_fetch_pkg;

    localparam int unsigned DIN_WIDTH = 9;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_HALT = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_MOVI = 3'b111;

    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0100;
    localparam logic [3:0] T4 = 4'b1000;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2,
        StHalt  = 2'd3
    } state_e;

    // Two-word instructions: the word after the opcode is an immediate.
    function automatic logic is_imm_op(input logic [OP_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_MOVI);
    endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: synchronous write port, asynchronous read port, contents never reset.
module prog_mem #(
    parameter int unsigned DIN_WIDTH = 9,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned DEPTH     = 64
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [DIN_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [DIN_WIDTH-1:0] rdata_o
);

    logic [DIN_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: program memory plus pc/FSM that presents the instruction word
// on tick 1 and, for ADDI/MOVI, the immediate word on tick 2.
module instr_fetch #(
    parameter int unsigned DIN_WIDTH = instr_fetch_pkg::DIN_WIDTH,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned DEPTH     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           tick,
    input  logic                 start,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [DIN_WIDTH-1:0] prog_data,
    output logic [DIN_WIDTH-1:0] din,
    output logic [ADDR_W-1:0]    pc,
    output logic                 running,
    output logic                 halted,
    output logic [15:0]          instr_count
);

    import instr_fetch_pkg::*;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [15:0]         cnt_q;
    logic                imm_q;

    logic [DIN_WIDTH-1:0] rdata;
    logic [OP_W-1:0]      opcode;
    logic                 fetch;
    logic                 imm_slot;
    logic                 mem_we;
    logic                 last;

    // Memory may only be reprogrammed while nothing is executing.
    assign mem_we = prog_we && !rst && ((state_q == StLoad) || (state_q == StHalt));

    prog_mem #(
        .DIN_WIDTH (DIN_WIDTH),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH)
    ) u_prog_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    assign opcode   = rdata[DIN_WIDTH-1 -: OP_W];
    assign fetch    = ((state_q == StRun) || (state_q == StArmed)) && (tick == T1);
    assign imm_slot = (state_q == StRun) && (tick == T2) && imm_q;
    assign last     = (pc_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            pc_q    <= '0;
            cnt_q   <= '0;
            imm_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad, StHalt: begin
                    if (start) begin
                        state_q <= StArmed;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                        imm_q   <= 1'b0;
                    end
                end
                StArmed, StRun: begin
                    if (fetch) begin
                        if (opcode == OP_HALT) begin
                            state_q <= StHalt;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                            imm_q <= is_imm_op(opcode);
                            // No wrap: stepping past the last word halts.
                            if (last) begin
                                state_q <= StHalt;
                            end else begin
                                pc_q    <= pc_q + ADDR_W'(1);
                                state_q <= StRun;
                            end
                        end
                    end else if (imm_slot) begin
                        imm_q <= 1'b0;
                        if (last) begin
                            state_q <= StHalt;
                        end else begin
                            pc_q <= pc_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign din         = (fetch || imm_slot) ? rdata : '0;
    assign pc          = pc_q;
    assign running     = (state_q == StArmed) || (state_q == StRun);
    assign halted      = (state_q == StHalt);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized programs,
// all compared every cycle against a behavioural model of the fetch stage.
module tb_instr_fetch;

    localparam int DEPTH = 64;
    localparam int MLoad = 0, MArmed = 1, MRun = 2, MHalt = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  tick = 4'b0001;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [8:0]  prog_data = '0;
    logic [8:0]  din;
    logic [5:0]  pc;
    logic        running;
    logic        halted;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    instr_fetch #(
        .DIN_WIDTH (9),
        .ADDR_W    (6),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .din         (din),
        .pc          (pc),
        .running     (running),
        .halted      (halted),
        .instr_count (instr_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: what the processor should be offered, from the program and the tick.
    int         m_mode = MLoad;
    int         m_pc   = 0;
    int         m_cnt  = 0;
    bit         m_imm  = 1'b0;
    logic [8:0] m_mem [DEPTH];

    function automatic bit m_fetch();
        return ((m_mode == MArmed) || (m_mode == MRun)) && (tick == 4'b0001);
    endfunction

    function automatic bit m_imm_slot();
        return (m_mode == MRun) && (tick == 4'b0010) && m_imm;
    endfunction

    function automatic logic [8:0] m_din();
        if (m_fetch() || m_imm_slot()) return m_mem[m_pc];
        return 9'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= MLoad;
            m_pc   <= 0;
            m_cnt  <= 0;
            m_imm  <= 1'b0;
        end else if ((m_mode == MLoad) || (m_mode == MHalt)) begin
            if (prog_we) m_mem[prog_addr] <= prog_data;
            if (start) begin
                m_mode <= MArmed;
                m_pc   <= 0;
                m_cnt  <= 0;
                m_imm  <= 1'b0;
            end
        end else if (m_fetch()) begin
            if (m_mem[m_pc][8:6] == 3'b000) begin
                m_mode <= MHalt;
            end else begin
                m_cnt <= (m_cnt + 1) % 65536;
                m_imm <= (m_mem[m_pc][8:6] == 3'b010) || (m_mem[m_pc][8:6] == 3'b111);
                if (m_pc == DEPTH - 1) m_mode <= MHalt;
                else begin
                    m_pc   <= m_pc + 1;
                    m_mode <= MRun;
                end
            end
        end else if (m_imm_slot()) begin
            m_imm <= 1'b0;
            if (m_pc == DEPTH - 1) m_mode <= MHalt;
            else m_pc <= m_pc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("din", 32'(din), 32'(m_din()));
            check("pc", 32'(pc), 32'(m_pc));
            check("running", 32'(running), 32'((m_mode == MArmed) || (m_mode == MRun)));
            check("halted", 32'(halted), 32'(m_mode == MHalt));
            check("instr_count", 32'(instr_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        tick    = {tick[2:0], tick[3]};
    endtask

    task automatic write(input int a, input logic [8:0] d);
        prog_we   = 1'b1;
        prog_addr = 6'(a);
        prog_data = d;
        step();
    endtask

    task automatic go();
        start = 1'b1;
        step();
    endtask

    task automatic wait_tick(input logic [3:0] t);
        for (int k = 0; k < 8 && tick !== t; k++) step();
    endtask

    task automatic wait_halt(input string name, input int budget);
        for (int k = 0; k < budget && halted !== 1'b1; k++) step();
        #2;
        check(name, 32'(halted), 32'd1);
    endtask

    initial begin
        repeat (2) step();
        #2;
        check("reset din", 32'(din), 32'd0);
        check("reset pc", 32'(pc), 32'd0);
        check("reset running", 32'(running), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset count", 32'(instr_count), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) write(a, 9'd0);

        // MOVI R0,5 ; ADD R0,R0 ; HALT
        write(0, 9'h1C0);
        write(1, 9'd5);
        write(2, 9'h040);
        write(3, 9'd0);
        wait_tick(4'b1000);
        go();
        #2;
        check("t1 movi word", 32'(din), 32'h1C0);
        step();
        #2;
        check("t1 imm word", 32'(din), 32'd5);
        wait_tick(4'b0001);
        #2;
        check("t1 add word", 32'(din), 32'h040);
        wait_halt("t1 halted", 40);
        check("t1 pc", 32'(pc), 32'd3);
        check("t1 count", 32'(instr_count), 32'd2);

        // start during tick 3: nothing offered until tick 1
        wait_tick(4'b0100);
        go();
        #2;
        check("t2 din armed", 32'(din), 32'd0);
        check("t2 running", 32'(running), 32'd1);
        step();
        #2;
        check("t2 first fetch", 32'(din), 32'h1C0);
        wait_halt("t2 halted", 40);

        // full memory of ADDs runs to the end without wrapping
        for (int a = 0; a < DEPTH; a++) write(a, 9'h040);
        go();
        wait_halt("t3 halted", 600);
        check("t3 pc", 32'(pc), 32'd63);
        check("t3 count", 32'(instr_count), 32'd64);

        // ADDI in the last word: its immediate slot is not offered
        write(63, 9'h088);
        go();
        for (int k = 0; k < 600 && !(pc == 6'd63 && tick == 4'b0001); k++) step();
        step();
        #2;
        check("t4 tick", 32'(tick), 32'h2);
        check("t4 halted", 32'(halted), 32'd1);
        check("t4 din", 32'(din), 32'd0);
        check("t4 count", 32'(instr_count), 32'd64);

        // writes during RUN are ignored
        write(0, 9'h040);
        go();
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            prog_we   = 1'b1;
            prog_addr = 6'd0;
            prog_data = 9'h1FF;
            step();
        end
        wait_halt("t5 halted", 600);
        wait_tick(4'b1000);
        go();
        #2;
        check("t5 mem0 kept", 32'(din), 32'h040);
        wait_halt("t5 halted again", 600);

        // reset during the MOVI immediate slot, then rerun
        write(0, 9'h1C0);
        write(1, 9'd7);
        for (int a = 2; a < 5; a++) write(a, 9'h040);
        write(5, 9'd0);
        go();
        for (int k = 0; k < 20 && !(pc == 6'd1 && tick == 4'b0010); k++) step();
        rst = 1'b1;
        step();
        #2;
        check("t6 pc", 32'(pc), 32'd0);
        check("t6 din", 32'(din), 32'd0);
        check("t6 count", 32'(instr_count), 32'd0);
        check("t6 running", 32'(running), 32'd0);
        rst = 1'b0;
        go();
        wait_halt("t6 halted", 100);
        check("t6 rerun count", 32'(instr_count), 32'd4);
        check("t6 rerun pc", 32'(pc), 32'd5);

        // randomized programs, start phases, stray writes and resets
        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < DEPTH; a++) write(a, 9'($urandom));
            repeat ($urandom_range(0, 3)) step();
            prog_we   = 1'($urandom);
            prog_addr = 6'($urandom);
            prog_data = 9'($urandom);
            start     = 1'b1;
            step();
            for (int k = 0; k < 300 && halted !== 1'b1; k++) begin
                prog_we   = ($urandom_range(0, 7) == 0);
                prog_addr = 6'($urandom);
                prog_data = 9'($urandom);
                start     = ($urandom_range(0, 15) == 0);
                if (r % 4 == 3 && k == 20) rst = 1'b1;
                step();
                if (rst) begin
                    rst = 1'b0;
                    break;
                end
            end
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
